// File: rtl/mult_tt_pkg.sv
// rtl/mult_tt_pkg.sv - shared state encodings and counter sizing for the taint-tracked multiplier controller
package mult_tt_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        TEST  = 3'd2,
        ADD   = 3'd3,
        SHIFT = 3'd4,
        DONE  = 3'd5
    } state_e;

    // Iteration counter width; a one-bit operand still needs a one-bit counter.
    function automatic int cnt_w(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/mult_tt_iter_counter.sv
// rtl/mult_tt_iter_counter.sv - multiplier bit-index counter with clear, increment and terminal flag
module mult_tt_iter_counter
    import mult_tt_pkg::*;
#(
    parameter int WIDTH = 2048,
    localparam int CNT_W = cnt_w(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt,
    output logic             last
);

    // Clear wins over increment; the controller never increments past the terminal value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign last = (cnt == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/multiplier_controller_taint_track.sv
// rtl/multiplier_controller_taint_track.sv - shift-add multiplier FSM with control-flow taint; CONST_TIME_EN selects the data-independent schedule
module multiplier_controller_taint_track
    import mult_tt_pkg::*;
#(
    parameter int WIDTH = 2048
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             start_t,
    input  logic [WIDTH-1:0] multiplierReg,
    input  logic [WIDTH-1:0] multiplierReg_t,
    output logic             mrld,
    output logic             mdld,
    output logic             rsclear,
    output logic             rsload,
    output logic             rsshr,
    output logic             mrld_t,
    output logic             mdld_t,
    output logic             rsclear_t,
    output logic             rsload_t,
    output logic             rsshr_t,
    output logic             busy,
    output logic             done,
    output logic             done_t
);

    localparam int CNT_W = cnt_w(WIDTH);

    state_e           state, state_nx;
    logic             state_t, state_t_nx;
    logic             bit_t, bit_t_nx;
    logic             cnt_clear, cnt_inc, cnt_last;
    logic [CNT_W-1:0] cnt;
`ifdef CONST_TIME_EN
    logic             bit_r, bit_r_nx;
`endif

    mult_tt_iter_counter #(.WIDTH(WIDTH)) u_cnt (
        .clk   (clk),
        .rst   (rst),
        .clear (cnt_clear),
        .inc   (cnt_inc),
        .cnt   (cnt),
        .last  (cnt_last)
    );

    // State and taint registers; reset drops straight back to a clean IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            state_t <= 1'b0;
            bit_t   <= 1'b0;
`ifdef CONST_TIME_EN
            bit_r   <= 1'b0;
`endif
        end else begin
            state   <= state_nx;
            state_t <= state_t_nx;
            bit_t   <= bit_t_nx;
`ifdef CONST_TIME_EN
            bit_r   <= bit_r_nx;
`endif
        end
    end

    // Next-state, taint propagation and counter control.
    always_comb begin
        state_nx   = state;
        state_t_nx = state_t;
        bit_t_nx   = bit_t;
        cnt_clear  = 1'b0;
        cnt_inc    = 1'b0;
`ifdef CONST_TIME_EN
        bit_r_nx   = bit_r;
`endif
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx   = LOAD;
                    state_t_nx = start_t;
                    cnt_clear  = 1'b1;
                end
            end
            LOAD: state_nx = TEST;
            TEST: begin
                bit_t_nx = multiplierReg_t[cnt];
`ifdef CONST_TIME_EN
                // Always visit ADD so timing never depends on the multiplier value.
                bit_r_nx = multiplierReg[cnt];
                state_nx = ADD;
`else
                // Branching on a tainted bit taints everything that follows.
                state_t_nx = state_t | multiplierReg_t[cnt];
                state_nx   = multiplierReg[cnt] ? ADD : SHIFT;
`endif
            end
            ADD: state_nx = SHIFT;
            SHIFT: begin
                // Terminal check precedes the increment so the counter never wraps.
                if (cnt_last) begin
                    state_nx = DONE;
                end else begin
                    cnt_inc  = 1'b1;
                    state_nx = TEST;
                end
            end
            DONE: begin
                state_nx   = IDLE;
                state_t_nx = 1'b0;
                bit_t_nx   = 1'b0;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Moore output decode; every taint output follows state_t except rsload_t in ADD.
    always_comb begin
        mrld      = 1'b0;
        mdld      = 1'b0;
        rsclear   = 1'b0;
        rsload    = 1'b0;
        rsshr     = 1'b0;
        done      = 1'b0;
        busy      = (state != IDLE);
        mrld_t    = state_t;
        mdld_t    = state_t;
        rsclear_t = state_t;
        rsload_t  = state_t;
        rsshr_t   = state_t;
        done_t    = state_t;
        case (state)
            LOAD: begin
                mrld    = 1'b1;
                mdld    = 1'b1;
                rsclear = 1'b1;
            end
            ADD: begin
`ifdef CONST_TIME_EN
                rsload   = bit_r;
`else
                rsload   = 1'b1;
`endif
                rsload_t = state_t | bit_t;
            end
            SHIFT:   rsshr = 1'b1;
            DONE:    done  = 1'b1;
            default: ;
        endcase
    end

endmodule
